// File: rtl/pipe_stage_buffer.sv
// Elastic inter-stage pipeline register: DEPTH-entry circular buffer with
// valid/ready on both sides, synchronous flush and an overflow-attempt pulse.
module pipe_stage_buffer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  in_valid_in,
    input  logic [DATA_WIDTH-1:0] in_data_in,
    output logic                  in_ready_out,
    output logic                  out_valid_out,
    output logic [DATA_WIDTH-1:0] out_data_out,
    input  logic                  out_ready_in,
    input  logic                  flush_in,
    output logic [CNT_WIDTH-1:0]  count_out,
    output logic                  drop_out
);

    localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_drop;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Explicit wrap so non-power-of-two depths cycle correctly.
    function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    // Flags come from registered occupancy only; no out_ready -> in_ready path.
    assign w_full  = (r_count == CNT_WIDTH'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid_in & ~w_full;
    assign w_pop   = ~w_empty & out_ready_in;

    assign in_ready_out  = ~w_full;
    assign out_valid_out = ~w_empty;
    assign out_data_out  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count_out     = r_count;
    assign drop_out      = r_drop;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_drop   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_drop <= in_valid_in & w_full & ~flush_in;
            if (flush_in) begin
                // Squash wins over any same-cycle push or pop; storage is left stale.
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= in_data_in;
                    r_wr_ptr        <= ptr_next(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_next(r_rd_ptr);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                    2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: a DEPTH=4 instance for fill/drain,
// stream, flush and async reset, and a DEPTH=3 instance for pointer wrap.
module tb_pipe_stage_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_in_valid = 1'b0;
    logic [63:0] a_in_data  = '0;
    logic        a_in_ready;
    logic        a_out_valid;
    logic [63:0] a_out_data;
    logic        a_out_ready = 1'b0;
    logic        a_flush = 1'b0;
    logic [2:0]  a_count;
    logic        a_drop;

    logic        b_in_valid = 1'b0;
    logic [63:0] b_in_data  = '0;
    logic        b_in_ready;
    logic        b_out_valid;
    logic [63:0] b_out_data;
    logic        b_out_ready = 1'b0;
    logic        b_flush = 1'b0;
    logic [1:0]  b_count;
    logic        b_drop;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_buffer #(.DATA_WIDTH(64), .DEPTH(4)) u_dut_a (
        .clock_in      (clk),
        .reset_in      (rst),
        .in_valid_in   (a_in_valid),
        .in_data_in    (a_in_data),
        .in_ready_out  (a_in_ready),
        .out_valid_out (a_out_valid),
        .out_data_out  (a_out_data),
        .out_ready_in  (a_out_ready),
        .flush_in      (a_flush),
        .count_out     (a_count),
        .drop_out      (a_drop)
    );

    pipe_stage_buffer #(.DATA_WIDTH(64), .DEPTH(3)) u_dut_b (
        .clock_in      (clk),
        .reset_in      (rst),
        .in_valid_in   (b_in_valid),
        .in_data_in    (b_in_data),
        .in_ready_out  (b_in_ready),
        .out_valid_out (b_out_valid),
        .out_data_out  (b_out_data),
        .out_ready_in  (b_out_ready),
        .flush_in      (b_flush),
        .count_out     (b_count),
        .drop_out      (b_drop)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, checked while reset is held.
        #12;
        chk("rst_ready", 64'(a_in_ready), 64'd1);
        chk("rst_valid", 64'(a_out_valid), 64'd0);
        chk("rst_data",  a_out_data, 64'd0);
        chk("rst_count", 64'(a_count), 64'd0);
        chk("rst_drop",  64'(a_drop), 64'd0);
        rst = 1'b0;
        step();
        chk("idle_ready", 64'(a_in_ready), 64'd1);
        chk("idle_count", 64'(a_count), 64'd0);

        // Fill to full with downstream stalled.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in_data = 64'hA + 64'(i);
            step();
        end
        chk("full_count", 64'(a_count), 64'd4);
        chk("full_ready", 64'(a_in_ready), 64'd0);
        chk("full_head",  a_out_data, 64'hA);
        chk("full_drop0", 64'(a_drop), 64'd0);

        // Offer a 5th word while full: one drop pulse, nothing stored.
        a_in_data = 64'hE;
        step();
        chk("drop_pulse", 64'(a_drop), 64'd1);
        chk("drop_count", 64'(a_count), 64'd4);
        a_in_valid = 1'b0;
        step();
        chk("drop_clear", 64'(a_drop), 64'd0);
        chk("drop_head",  a_out_data, 64'hA);

        // Drain in order.
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", a_out_data, 64'hA + 64'(i));
            step();
        end
        chk("drain_valid", 64'(a_out_valid), 64'd0);
        chk("drain_data0", a_out_data, 64'd0);
        chk("drain_count", 64'(a_count), 64'd0);

        // Stream 1..10 with both sides ready.
        a_in_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            a_in_data = 64'(k);
            step();
            chk("strm_data",  a_out_data, 64'(k));
            chk("strm_count", 64'(a_count), 64'd1);
        end
        a_in_valid = 1'b0;
        step();
        chk("strm_end", 64'(a_count), 64'd0);

        // Flush at count 2 together with a push of 0x55 and a pop.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 64'h11;
        step();
        a_in_data   = 64'h22;
        step();
        chk("fl_pre_count", 64'(a_count), 64'd2);
        a_in_data   = 64'h55;
        a_out_ready = 1'b1;
        a_flush     = 1'b1;
        step();
        chk("fl_count", 64'(a_count), 64'd0);
        chk("fl_valid", 64'(a_out_valid), 64'd0);
        chk("fl_data",  a_out_data, 64'd0);
        chk("fl_drop",  64'(a_drop), 64'd0);
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        step();
        chk("fl_after_valid", 64'(a_out_valid), 64'd0);
        chk("fl_after_ready", 64'(a_in_ready), 64'd1);

        // Asynchronous reset mid-stream at count 3.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            a_in_data = 64'h30 + 64'(i);
            step();
        end
        chk("ar_pre_count", 64'(a_count), 64'd3);
        a_in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_count", 64'(a_count), 64'd0);
        chk("ar_valid", 64'(a_out_valid), 64'd0);
        chk("ar_data",  a_out_data, 64'd0);
        chk("ar_ready", 64'(a_in_ready), 64'd1);
        #1 rst = 1'b0;
        a_in_valid = 1'b1;
        a_in_data  = 64'h77;
        step();
        a_in_valid = 1'b0;
        chk("ar_head",  a_out_data, 64'h77);
        chk("ar_count1", 64'(a_count), 64'd1);

        // DEPTH=3: stream 1..10 wraps both pointers several times.
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            b_in_data = 64'(k);
            step();
            chk("d3_strm_data",  b_out_data, 64'(k));
            chk("d3_strm_count", 64'(b_count), 64'd1);
        end
        b_in_valid = 1'b0;
        step();
        chk("d3_empty", 64'(b_count), 64'd0);

        // DEPTH=3: fill from pointer 1 so the write pointer crosses 0, then drain.
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_in_data = 64'hC0 + 64'(i);
            step();
        end
        b_in_valid = 1'b0;
        chk("d3_full_count", 64'(b_count), 64'd3);
        chk("d3_full_ready", 64'(b_in_ready), 64'd0);
        b_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("d3_drain", b_out_data, 64'hC0 + 64'(i));
            step();
        end
        chk("d3_drain_valid", 64'(b_out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Backstop against a stalled run.
    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish by 20000");
        $fatal(1);
    end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
- Parametrised elastic pipeline register with a valid/ready handshake on both sides, a DEPTH-entry circular buffer, and a synchronous flush.
- Successor to the fixed, always-set inter-stage REG instances (IF/ID, ID/IS, IS/EX, EX/WB). Each stage can now stall independently and absorb back-pressure.
- Each stage can also be squashed on a branch or exception.
- Sits between any two pipeline stages; the upstream stage drives the in_* side and the downstream stage consumes the out_* side.

Parameters:
- DATA_WIDTH, 64: payload width in bits (e.g. 64 for IF/ID {IR,PC}, 143 for ID/IS).
- DEPTH, 2: number of buffer entries; legal range 1..16, any integer (not restricted to powers of two).
- CNT_WIDTH, $clog2(DEPTH+1): width of the occupancy count; derived, not overridden.

Ports:
- clock_in  input  1  core clock; all state updates on rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- in_valid_in  input  1  upstream presents a word.
- in_data_in  input  DATA_WIDTH  upstream payload.
- in_ready_out  output  1  buffer can accept a word this cycle.
- out_valid_out  output  1  head word is valid.
- out_data_out  output  DATA_WIDTH  head payload.
- out_ready_in  input  1  downstream consumes the head this cycle.
- flush_in  input  1  synchronous squash of all buffered words.
- count_out  output  CNT_WIDTH  current occupancy.
- drop_out  output  1  one-cycle pulse when in_valid_in is high while in_ready_out is low.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears the read pointer, write pointer and count to 0, and all storage entries to 0.
  - Output values during and after reset: in_ready_out=1, out_valid_out=0, out_data_out=0, count_out=0, drop_out=0.
  - Asserting reset mid-transfer discards all content immediately, without waiting for a clock edge.
- Flags:
  - full = (count == DEPTH); empty = (count == 0).
  - in_ready_out = !full, derived from registered state only. There is no combinational path from out_ready_in to in_ready_out.
  - out_valid_out = !empty.
  - out_data_out = storage[rd_ptr] when !empty, forced to 0 when empty.
- Push and pop:
  - push = in_valid_in & in_ready_out: write storage[wr_ptr], then wr_ptr advances.
  - pop = out_valid_out & out_ready_in: rd_ptr advances.
- Pointer wrap: each pointer wraps from DEPTH-1 to 0. This must work for non-power-of-two DEPTH (e.g. 3).
- Count update:
  - +1 on push only; -1 on pop only; unchanged on simultaneous push+pop.
  - Simultaneous push+pop is legal only when not full, because a full buffer deasserts ready. There is no same-cycle pass-through.
- Latency: a word pushed at edge N is visible on out_* after edge N (one-cycle minimum latency). Throughput is one word per cycle when DEPTH≥2 and downstream is always ready.
- DEPTH=1: ready is low while the entry is occupied, so steady-state throughput is at most one word per 2 cycles. This is the intended behaviour.
- Flush:
  - At the clock edge it sets pointers and count to 0.
  - It overrides a push and a pop in the same cycle; the incoming word is discarded, not stored.
  - Storage contents are left as-is, but out_data_out reads 0 because the buffer is empty.
  - drop_out is not raised for a word discarded by flush.
- drop_out: registered, high for exactly the cycle after an edge at which in_valid_in=1 and full=1 (and flush_in=0). It flags upstream protocol misuse.
- Handshake rules:
  - The upstream stage must hold in_data_in stable while in_valid_in=1 and in_ready_out=0.
  - out_data_out stays stable while out_valid_out=1 and out_ready_in=0.

Test Plan (DATA_WIDTH=64, DEPTH=4 unless stated):
- Reset then idle -> in_ready_out=1, out_valid_out=0, out_data_out=0, count_out=0.
- Push 0xA, 0xB, 0xC, 0xD on consecutive cycles with out_ready_in=0 -> count_out=4, in_ready_out=0, out_data_out=0xA. A 5th valid word 0xE -> drop_out pulses once, count stays 4.
- From full, out_ready_in=1 for 4 cycles -> out_data_out sequence 0xA, 0xB, 0xC, 0xD, then out_valid_out=0 and out_data_out=0.
- Stream 10 words 1..10 with both sides always ready -> outputs 1..10 in order, one per cycle after a 1-cycle latency, count_out steady at 1. Repeat with DEPTH=3 to check pointer wrap across 0.
- Count 2 with flush_in=1 asserted on the same edge as a push of 0x55 and a pop -> count_out=0, out_valid_out=0, and 0x55 never appears at the output.
- Assert reset_in asynchronously mid-stream at count 3 -> outputs return to reset values before the next clock edge; the first post-reset push of 0x77 appears as the head word.
